// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the synchronous FIFO family.
//   clog2      - ceiling log2 for sizing counters and addresses
//   fifo_depth - entry count derived from the address width
//   thresh_ok  - legal almost-full/almost-empty threshold ranges for a depth
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic bit thresh_ok(input int af, input int ae, input int depth);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: simple dual-port RAM, synchronous write, asynchronous read.
//   i_clk   - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data, combinational from i_raddr
module fifo_ram_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_ext.sv
// fifo_sync_ext: single-clock FIFO with thresholds, occupancy, error pulses and optional FWFT.
//   i_clk, i_rst          - clock, synchronous active-high reset
//   i_wr_en, i_din        - write request and data
//   i_rd_en               - read request (pop/acknowledge in FWFT mode)
//   o_dout                - read data
//   o_full, o_empty       - count == DEPTH, count == 0
//   o_almost_full/_empty  - count >= AF_THRESH, count <= AE_THRESH
//   o_count               - occupancy 0..DEPTH
//   o_overflow/underflow  - one-cycle pulses for rejected write/read
module fifo_sync_ext
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int                DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam int                CW      = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] L_DEPTH = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_AF    = CW'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] L_AE    = CW'(AE_THRESH);

    if (!thresh_ok(AF_THRESH, AE_THRESH, DEPTH)) begin : g_bad_thresh
        $error("fifo_sync_ext: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
    end

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Wrap bit in the pointer MSB makes the plain difference the occupancy.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == L_DEPTH);
    assign w_empty = (w_count == '0);
    assign w_rd_ok = i_rd_en & ~w_empty;
    // A write into a full FIFO is safe only when a slot frees on the same edge.
    assign w_wr_ok = i_wr_en & (~w_full | i_rd_en);
    // FWFT keeps a shadow of the head word so dout stays stable once empty.
    assign w_load  = (FWFT != 0) ? ~w_empty : w_rd_ok;

    fifo_ram_2p #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (w_wr_ok),
        .i_waddr(r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata(i_din),
        .i_raddr(r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata(w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_dout      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_load)  r_dout   <= w_rd_data;
            r_overflow  <= i_wr_en & w_full & ~i_rd_en;
            r_underflow <= i_rd_en & w_empty;
        end
    end

    assign o_dout         = ((FWFT != 0) && !w_empty) ? w_rd_data : r_dout;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (w_count >= L_AF);
    assign o_almost_empty = (w_count <= L_AE);
    assign o_count        = w_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule
